// File: rtl/md_pkg.sv
// md_pkg: shared encodings and defaults for the multiply/divide scheduler.
//   md_op_e     : operation code presented by the EX stage
//   md_state_e  : scheduler FSM state encoding
//   MD_*_CYCLES_DEF : default busy latencies
//   md_cnt_width    : latency counter width for a given pair of latencies
package md_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_BUSY = 2'd1,
    DIV_BUSY = 2'd2
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Counter must hold (latency - 1) of the longer op; never narrower than 1 bit.
  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    int m;
    m = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/md_sched_if.sv
// md_sched_if: EX-stage <-> multiply/divide scheduler bundle.
//   start, op, A, B : operation request from EX (operands already forwarded)
//   id_md           : ID-stage instruction touches HI/LO
//   HI, LO          : architectural HI/LO registers
//   busy            : an operation is in flight
//   md_stall        : stall request to the hazard unit
//   cancel          : abort in-flight op / suppress start (only with MD_CANCEL_EN)
// master = pipeline side, slave = md_sched.
interface md_sched_if;
  import md_pkg::*;

  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        id_md;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        busy;
  logic        md_stall;
`ifdef MD_CANCEL_EN
  logic        cancel;

  modport master (output start, op, A, B, id_md, cancel,
                  input  HI, LO, busy, md_stall);
  modport slave  (input  start, op, A, B, id_md, cancel,
                  output HI, LO, busy, md_stall);
`else
  modport master (output start, op, A, B, id_md,
                  input  HI, LO, busy, md_stall);
  modport slave  (input  start, op, A, B, id_md,
                  output HI, LO, busy, md_stall);
`endif

endinterface

// File: rtl/md_alu.sv
// md_alu: combinational multiply/divide datapath.
//   op          : md_op_e code
//   a, b        : rs / rt operands
//   result      : {HI, LO}; product for MULT(U), {remainder, quotient} for DIV(U)
//   div_by_zero : divide op with b == 0 (result then meaningless)
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] sa_s;
  logic signed [63:0] sb_s;
  logic signed [63:0] sprod_s;
  logic [63:0]        uprod_s;
  logic               a_neg_s;
  logic               b_neg_s;
  logic [31:0]        a_mag_s;
  logic [31:0]        b_mag_s;
  logic [31:0]        q_mag_s;
  logic [31:0]        r_mag_s;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;

  assign sa_s    = {{32{a[31]}}, a};
  assign sb_s    = {{32{b[31]}}, b};
  assign sprod_s = sa_s * sb_s;
  assign uprod_s = {32'd0, a} * {32'd0, b};

  // Signed divide runs on magnitudes; quotient negated when signs differ,
  // remainder follows the dividend. -2^31 / -1 wraps to 0x80000000.
  assign a_neg_s = (op == MD_DIV) && a[31];
  assign b_neg_s = (op == MD_DIV) && b[31];
  assign a_mag_s = a_neg_s ? (32'd0 - a) : a;
  // Divisor forced to 1 on zero so the divider never sees x/0.
  assign b_mag_s = (b == 32'd0) ? 32'd1 : (b_neg_s ? (32'd0 - b) : b);
  assign q_mag_s = a_mag_s / b_mag_s;
  assign r_mag_s = a_mag_s % b_mag_s;
  assign quot_s  = (a_neg_s ^ b_neg_s) ? (32'd0 - q_mag_s) : q_mag_s;
  assign rem_s   = a_neg_s ? (32'd0 - r_mag_s) : r_mag_s;

  // Select the result for the requested operation.
  always_comb begin
    result      = 64'd0;
    div_by_zero = 1'b0;
    case (op)
      MD_MULT:  result = sprod_s;
      MD_MULTU: result = uprod_s;
      MD_DIV, MD_DIVU: begin
        result      = {rem_s, quot_s};
        div_by_zero = (b == 32'd0);
      end
      default: begin
        result      = 64'd0;
        div_by_zero = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// md_sched: multi-cycle multiply/divide scheduler beside the EX-stage ALU.
// Ports:
//   clk   : pipeline clock, rising edge
//   reset : asynchronous, active-low
//   bus   : md_sched_if.slave (start/op/A/B/id_md in; HI/LO/busy/md_stall out;
//           cancel in when MD_CANCEL_EN is defined)
// An op sampled at edge E0 holds busy for exactly N edges (N = MULT_CYCLES or
// DIV_CYCLES) and commits to {HI,LO} at E_N. MTHI/MTLO write in one edge.
// md_stall is combinational: id_md & (busy | start).
// Optional feature macro: MD_CANCEL_EN (adds cancel input; abort / suppress).
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
)
(
  input logic        clk,
  input logic        reset,
  md_sched_if.slave  bus
);

  localparam int               CNT_W     = md_cnt_width(MULT_CYCLES, DIV_CYCLES);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

  md_state_e        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [63:0]      shadow_r;
  logic             shadow_dbz_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;
  logic             busy_r;
  logic [63:0]      alu_result_s;
  logic             alu_dbz_s;
  logic             cancel_s;

`ifdef MD_CANCEL_EN
  assign cancel_s = bus.cancel;
`else
  assign cancel_s = 1'b0;
`endif

  md_alu u_alu (
    .op          (bus.op),
    .a           (bus.A),
    .b           (bus.B),
    .result      (alu_result_s),
    .div_by_zero (alu_dbz_s)
  );

  // Scheduler FSM: accept ops in IDLE, count down latency, commit shadow to HI/LO.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      cnt_r        <= CNT_ZERO;
      shadow_r     <= 64'd0;
      shadow_dbz_r <= 1'b0;
      hi_r         <= 32'd0;
      lo_r         <= 32'd0;
      busy_r       <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start && !cancel_s) begin
            case (bus.op)
              MD_MULT, MD_MULTU: begin
                shadow_r     <= alu_result_s;
                shadow_dbz_r <= 1'b0;
                cnt_r        <= MULT_LOAD;
                state_r      <= MUL_BUSY;
                busy_r       <= 1'b1;
              end
              MD_DIV, MD_DIVU: begin
                shadow_r     <= alu_result_s;
                shadow_dbz_r <= alu_dbz_s;
                cnt_r        <= DIV_LOAD;
                state_r      <= DIV_BUSY;
                busy_r       <= 1'b1;
              end
              MD_MTHI: hi_r <= bus.A;
              MD_MTLO: lo_r <= bus.A;
              default: state_r <= IDLE;
            endcase
          end else begin
            state_r <= IDLE;
          end
        end
        MUL_BUSY, DIV_BUSY: begin
          // A start arriving here is a protocol violation and is ignored.
          if (cancel_s) begin
            // Cancel wins over a same-edge commit; HI/LO keep pre-op values.
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            cnt_r        <= CNT_ZERO;
            shadow_r     <= 64'd0;
            shadow_dbz_r <= 1'b0;
          end else if (cnt_r == CNT_ZERO) begin
            if (!shadow_dbz_r) begin
              hi_r <= shadow_r[63:32];
              lo_r <= shadow_r[31:0];
            end else begin
              hi_r <= hi_r;
            end
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= CNT_ZERO;
        end
      endcase
    end
  end

  assign bus.HI       = hi_r;
  assign bus.LO       = lo_r;
  assign bus.busy     = busy_r;
  // Stall a dependent ID instruction during the start cycle as well as while busy.
  assign bus.md_stall = bus.id_md & (busy_r | bus.start);

endmodule

// File: tb/tb_md_sched.sv
// tb_md_sched: directed + randomized bench for md_sched against a behavioural
// model (edges-remaining counter, 64-bit integer arithmetic).
module tb_md_sched;
  import md_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  bit   cmp_en = 1'b0;

  always #5 clk = ~clk;

  md_sched_if bus ();

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  logic cancel_now;
`ifdef MD_CANCEL_EN
  assign cancel_now = bus.cancel;
`else
  assign cancel_now = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {div_by_zero, HI, LO}.
  function automatic logic [64:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] w;
    logic [31:0] uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ref_op = 65'd0;
    case (o)
      MD_MULT: begin
        sp = sa * sb;
        w = sp;
        ref_op = {1'b0, w};
      end
      MD_MULTU: begin
        w = {32'd0, a} * {32'd0, b};
        ref_op = {1'b0, w};
      end
      MD_DIV: begin
        if (b == 32'd0) ref_op = {1'b1, 64'd0};
        else begin
          sq = sa / sb;
          sr = sa % sb;
          ref_op = {1'b0, sr[31:0], sq[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 32'd0) ref_op = {1'b1, 64'd0};
        else begin
          uq = a / b;
          ur = a % b;
          ref_op = {1'b0, ur, uq};
        end
      end
      default: ref_op = 65'd0;
    endcase
  endfunction

  // Behavioural model: m_left = edges remaining until commit (0 = idle).
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic [64:0] m_pres = 65'd0;
  int          m_left = 0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_left <= 0;
    end else if (m_left > 0) begin
      if (cancel_now) m_left <= 0;
      else begin
        m_left <= m_left - 1;
        if (m_left == 1 && !m_pres[64]) begin
          m_hi <= m_pres[63:32];
          m_lo <= m_pres[31:0];
        end
      end
    end else if (bus.start && !cancel_now) begin
      case (bus.op)
        MD_MULT, MD_MULTU: begin
          m_pres <= ref_op(bus.op, bus.A, bus.B);
          m_left <= MC;
        end
        MD_DIV, MD_DIVU: begin
          m_pres <= ref_op(bus.op, bus.A, bus.B);
          m_left <= DC;
        end
        MD_MTHI: m_hi <= bus.A;
        MD_MTLO: m_lo <= bus.A;
        default: ;
      endcase
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_busy", {31'd0, bus.busy}, {31'd0, (m_left > 0)});
      chk("cmp_hi", bus.HI, m_hi);
      chk("cmp_lo", bus.LO, m_lo);
      chk("cmp_stall", {31'd0, bus.md_stall},
          {31'd0, bus.id_md & ((m_left > 0) | bus.start)});
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
  endtask

  // Count busy cycles (called one step after the accepting edge); bounded.
  task automatic wait_idle(output int n);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int n;
    int k;
    bus.start = 1'b0; bus.op = MD_NONE; bus.A = 32'd0; bus.B = 32'd0; bus.id_md = 1'b0;
`ifdef MD_CANCEL_EN
    bus.cancel = 1'b0;
`endif
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state and start-only stall during reset.
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    bus.id_md = 1'b1; #1;
    chk("rst_stall_idle", {31'd0, bus.md_stall}, 32'd0);
    bus.start = 1'b1; #1;
    chk("rst_stall_start", {31'd0, bus.md_stall}, 32'd1);
    bus.start = 1'b0; bus.id_md = 1'b0;
    cmp_en = 1'b1;
    reset = 1'b1;

    issue(MD_MULT, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("mult_cycles", n, 32'd5);
    chk("mult_hi", bus.HI, 32'hFFFFFFFF);
    chk("mult_lo", bus.LO, 32'hFFFFFFFA);

    issue(MD_MULTU, 32'hFFFFFFFE, 32'd3);
    wait_idle(n);
    chk("multu_cycles", n, 32'd5);
    chk("multu_hi", bus.HI, 32'h00000002);
    chk("multu_lo", bus.LO, 32'hFFFFFFFA);

    issue(MD_DIV, 32'hFFFFFFF9, 32'd2);
    wait_idle(n);
    chk("div_cycles", n, 32'd10);
    chk("div_lo", bus.LO, 32'hFFFFFFFD);
    chk("div_hi", bus.HI, 32'hFFFFFFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle(n);
    chk("divu_lo", bus.LO, 32'd3);
    chk("divu_hi", bus.HI, 32'd1);

    issue(MD_MTLO, 32'h1234, 32'd0);
    chk("mtlo_busy", {31'd0, bus.busy}, 32'd0);
    chk("mtlo_lo", bus.LO, 32'h1234);

    issue(MD_DIV, 32'd5, 32'd0);
    wait_idle(n);
    chk("dbz_cycles", n, 32'd10);
    chk("dbz_lo", bus.LO, 32'h1234);
    chk("dbz_hi", bus.HI, 32'd1);

    // Stall coverage with id_md held, then back-to-back MULT after commit.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = MD_MULT; bus.A = 32'd2; bus.B = 32'd3; bus.id_md = 1'b1;
    #1 chk("stall_start_cycle", {31'd0, bus.md_stall}, 32'd1);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    n = 0;
    while (bus.busy && n < 100) begin
      chk("stall_busy_cycle", {31'd0, bus.md_stall}, 32'd1);
      n++;
      @(posedge clk); #1;
    end
    chk("stall_busy_count", n, 32'd5);
    chk("stall_after_commit", {31'd0, bus.md_stall}, 32'd0);
    chk("b2b_first_lo", bus.LO, 32'd6);
    bus.start = 1'b1; bus.op = MD_MULT; bus.A = 32'd4; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE;
    chk("b2b_accepted", {31'd0, bus.busy}, 32'd1);
    wait_idle(n);
    chk("b2b_lo", bus.LO, 32'd20);
    chk("b2b_hi", bus.HI, 32'd0);
    bus.id_md = 1'b0;

    // Asynchronous reset mid-clock in cycle 3 of a DIV.
    issue(MD_DIV, 32'd100, 32'd7);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("arst_busy", {31'd0, bus.busy}, 32'd0);
    chk("arst_hi", bus.HI, 32'd0);
    chk("arst_lo", bus.LO, 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    chk("arst_no_commit_lo", bus.LO, 32'd0);
    chk("arst_no_commit_busy", {31'd0, bus.busy}, 32'd0);

`ifdef MD_CANCEL_EN
    issue(MD_MTLO, 32'd5, 32'd0);
    issue(MD_MULT, 32'd2, 32'd3);
    @(posedge clk); #1 bus.cancel = 1'b1;
    @(posedge clk); #1 bus.cancel = 1'b0;
    chk("cancel_busy", {31'd0, bus.busy}, 32'd0);
    chk("cancel_lo", bus.LO, 32'd5);
    chk("cancel_hi", bus.HI, 32'd0);
    repeat (8) @(posedge clk);
    #1 chk("cancel_no_commit", bus.LO, 32'd5);
    bus.start = 1'b1; bus.op = MD_MTLO; bus.A = 32'd9; bus.cancel = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.op = MD_NONE; bus.cancel = 1'b0;
    chk("cancel_suppress_mtlo", bus.LO, 32'd5);
`endif

    // Randomized phase checked by the compare process.
    for (k = 0; k < 600; k++) begin
      @(posedge clk); #1;
      if (m_left == 0) bus.start = ($urandom_range(0, 2) == 0);
      else bus.start = ($urandom_range(0, 15) == 0);
      bus.op = 3'($urandom_range(0, 6));
      case ($urandom_range(0, 3))
        0: bus.A = 32'($urandom_range(0, 20));
        1: bus.A = 32'hFFFFFFFF - 32'($urandom_range(0, 20));
        2: bus.A = 32'h80000000;
        default: bus.A = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: bus.B = 32'd0;
        1: bus.B = 32'($urandom_range(1, 9));
        2: bus.B = 32'hFFFFFFFF - 32'($urandom_range(0, 9));
        default: bus.B = $urandom;
      endcase
      bus.id_md = 1'($urandom_range(0, 1));
`ifdef MD_CANCEL_EN
      bus.cancel = ($urandom_range(0, 19) == 0);
`endif
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    #1 cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
